matrix_scan_scheduler: RTL and testbench
========================================

# matrix_scan_scheduler

Top-level scan sequencer for the 16x8 LED matrix TX path. Walks the matrix column by column. Per column it:
- has the row-data SPI path load that column's pixels,
- drives `column_select` through its `select_first`/`select_next`/`ready` handshake,
- latches the row data,
- unblanks the matrix for a programmable dwell time.

It sits between the frame buffer/row serializer and `column_select` and owns all column timing.

## Interface
Parameters:
- `NUM_COLUMNS`, 16, columns per frame (≥2)
- `DWELL_W`, 16, width of `dwell_cycles`

Ports:
- `clk`  in  1  system clock. Single clock domain; asynchronous, active-low reset.
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  run scanning; sampled only at column boundaries and in S_IDLE
- `dwell_cycles`  in  DWELL_W  on-time per column in clk cycles; sampled at S_LATCH; 0 treated as 1
- `col_ready`  in  1  `ready` from `column_select`
- `select_first`  out  1  to `column_select`; column 0 request
- `select_next`  out  1  to `column_select`; advance request
- `row_start`  out  1  1-cycle pulse: row serializer loads column `col_idx`
- `row_done`  in  1  1-cycle pulse from row serializer: shift complete
- `row_latch`  out  1  1-cycle pulse: row STCP
- `col_idx`  out  $clog2(NUM_COLUMNS)  current column
- `blank`  out  1  1 = LEDs off (drives row OE)
- `frame_start`  out  1  1-cycle pulse when column 0 scan begins
- `busy`  out  1  high in every state except S_IDLE

## Operation
- Reset values: `select_first`=0, `select_next`=0, `row_start`=0, `row_latch`=0, `frame_start`=0, `busy`=0, `blank`=1, `col_idx`=0, state S_IDLE, dwell counter 0.
- States and transitions:
  - S_IDLE: `blank`=1. If `enable` && `col_ready`, go to S_ROW_LOAD with `col_idx`=0 and `frame_start` pulsed.
  - S_ROW_LOAD: `row_start`=1 for exactly one cycle (entry cycle), then wait `row_done`; on `row_done` go to S_COL_REQ.
  - S_COL_REQ: assert `select_first` if `col_idx`==0, else `select_next`. Hold it until `col_ready`==0, then go to S_COL_WAIT. Never assert both.
  - S_COL_WAIT: selects low; wait `col_ready`==1 (column shifted and STCP'd), then go to S_LATCH.
  - S_LATCH: `row_latch`=1 for one cycle; load counter with max(`dwell_cycles`,1); go to S_DWELL.
  - S_DWELL: `blank`=0; decrement counter; at counter==1, go to S_NEXT.
  - S_NEXT: `blank`=1. Set `col_idx` = (`col_idx`==NUM_COLUMNS-1) ? 0 : `col_idx`+1. Then:
    - if `enable`, go to S_ROW_LOAD, pulsing `frame_start` when the new index is 0;
    - else go to S_IDLE.
- `blank`=1 in every state except S_DWELL. Column switching is always blanked.
- `row_done` is ignored outside S_ROW_LOAD.
- `enable` falling mid-column does not abort the column; the scheduler stops at the next S_NEXT.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronous). Any in-flight `column_select` transfer is abandoned; `column_select` is reset from the same source.

## Timing
- All outputs are registered (Moore), so nothing combinational from inputs reaches outputs.
- `frame_start` and `row_start` assert in the same cycle.
- Dwell: `blank` is low for exactly max(`dwell_cycles`,1) cycles per column.
- S_ROW_LOAD → S_COL_REQ takes 1 cycle after `row_done` is sampled high.
- The select is high from the cycle after `row_done` until the cycle after `col_ready` is sampled low.
- Minimum column period = dwell + row-shift time + `column_select` round trip + 4 overhead cycles (ROW_LOAD entry, LATCH, NEXT, REQ).
- `col_idx` is stable from S_ROW_LOAD entry through S_NEXT.

## Structure
- Shared package `matrix_pkg`:
  - `scan_state_t` enum (S_IDLE, S_ROW_LOAD, S_COL_REQ, S_COL_WAIT, S_LATCH, S_DWELL, S_NEXT),
  - default `NUM_COLUMNS`/`NUM_ROWS`.
- One sub-module, `dwell_timer`: loadable down-counter with `load`, `value`, and a `done` output.
- FSM and column counter stay in the top module.

## Test plan
- Reset, then `enable`=1, `col_ready`=1, `row_done` returned 3 cycles after each `row_start`, `dwell_cycles`=10 → `frame_start` pulses once; `select_first` precedes `row_latch`; `blank` is low for exactly 10 cycles; `col_idx` reaches 1.
- Full frame with NUM_COLUMNS=16 → exactly 1 `select_first` and 15 `select_next`; `col_idx` wraps 15→0 and `frame_start` re-pulses.
- `dwell_cycles`=0 → `blank` is low exactly 1 cycle per column.
- `col_ready` held high for 5 cycles after a select asserts → select stays high all 5 cycles and drops the cycle after `col_ready` falls; never both selects high.
- `enable` dropped during S_DWELL of column 4 → column 4 dwell completes; `col_idx` becomes 5; S_IDLE with `blank`=1 and `busy`=0; re-enable restarts at column 0.
- `rst_n` pulsed low during S_COL_REQ → outputs are reset values in the same cycle; the next scan starts with `select_first`.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and defaults for the LED matrix scan path.
// No logic; consumed by the scheduler and its dwell timer.
package matrix_pkg;

    localparam int DEFAULT_NUM_COLUMNS = 16;
    localparam int DEFAULT_NUM_ROWS    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_LOAD,
        S_COL_REQ,
        S_COL_WAIT,
        S_LATCH,
        S_DWELL,
        S_NEXT
    } scan_state_t;

    // All scheduler outputs are registered together as one word.
    typedef struct packed {
        logic select_first;
        logic select_next;
        logic row_start;
        logic row_latch;
        logic frame_start;
        logic busy;
        logic blank;
    } scan_out_t;

    localparam scan_out_t SCAN_OUT_RESET = '{
        select_first: 1'b0,
        select_next:  1'b0,
        row_start:    1'b0,
        row_latch:    1'b0,
        frame_start:  1'b0,
        busy:         1'b0,
        blank:        1'b1
    };

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter timing the unblanked on-time of one column.
// done is high while the count is 1; no backpressure.
module dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // A zero dwell still gives one lit cycle, so load clamps to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= (value == '0) ? W'(1) : value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/matrix_scan_scheduler.sv
// Column scan sequencer: row load, column_select handshake, latch, dwell.
// All outputs registered (Moore); stalls on row_done and col_ready handshakes.
module matrix_scan_scheduler
    import matrix_pkg::*;
#(
    parameter int NUM_COLUMNS = DEFAULT_NUM_COLUMNS,
    parameter int DWELL_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [DWELL_W-1:0]             dwell_cycles,
    input  logic                           col_ready,
    output logic                           select_first,
    output logic                           select_next,
    output logic                           row_start,
    input  logic                           row_done,
    output logic                           row_latch,
    output logic [$clog2(NUM_COLUMNS)-1:0] col_idx,
    output logic                           blank,
    output logic                           frame_start,
    output logic                           busy
);

    localparam int            CW       = $clog2(NUM_COLUMNS);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLUMNS - 1);

    scan_state_t   state;
    scan_state_t   state_nxt;
    logic [CW-1:0] col_nxt;
    logic          frame_nxt;
    scan_out_t     out_q;
    scan_out_t     out_nxt;
    logic          dwell_done;

    dwell_timer #(
        .W (DWELL_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == S_LATCH),
        .value (dwell_cycles),
        .en    (state == S_DWELL),
        .done  (dwell_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            col_idx <= '0;
            out_q   <= SCAN_OUT_RESET;
        end else begin
            state   <= state_nxt;
            col_idx <= col_nxt;
            out_q   <= out_nxt;
        end
    end

    // col_idx only moves on leaving S_NEXT (or restarting from idle), so it
    // is stable for the whole column.
    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        frame_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && col_ready) begin
                    state_nxt = S_ROW_LOAD;
                    col_nxt   = '0;
                    frame_nxt = 1'b1;
                end
            end
            S_ROW_LOAD: begin
                if (row_done) begin
                    state_nxt = S_COL_REQ;
                end
            end
            S_COL_REQ: begin
                if (!col_ready) begin
                    state_nxt = S_COL_WAIT;
                end
            end
            S_COL_WAIT: begin
                if (col_ready) begin
                    state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                state_nxt = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_done) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                col_nxt = (col_idx == LAST_COL) ? '0 : col_idx + CW'(1);
                if (enable) begin
                    state_nxt = S_ROW_LOAD;
                    frame_nxt = (col_nxt == '0);
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        out_nxt              = SCAN_OUT_RESET;
        out_nxt.busy         = (state_nxt != S_IDLE);
        out_nxt.blank        = (state_nxt != S_DWELL);
        out_nxt.row_start    = (state_nxt == S_ROW_LOAD) && (state != S_ROW_LOAD);
        out_nxt.frame_start  = frame_nxt;
        out_nxt.select_first = (state_nxt == S_COL_REQ) && (col_nxt == '0);
        out_nxt.select_next  = (state_nxt == S_COL_REQ) && (col_nxt != '0);
        out_nxt.row_latch    = (state_nxt == S_LATCH);
    end

    assign select_first = out_q.select_first;
    assign select_next  = out_q.select_next;
    assign row_start    = out_q.row_start;
    assign row_latch    = out_q.row_latch;
    assign frame_start  = out_q.frame_start;
    assign busy         = out_q.busy;
    assign blank        = out_q.blank;

endmodule

// File: tb/tb_matrix_scan_scheduler.sv
// Directed, table-driven bench for matrix_scan_scheduler.
// Plays the row serializer and column_select roles from the main thread.
module tb_matrix_scan_scheduler;

    localparam int NC = 16;
    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] dwell_cycles;
    logic          col_ready;
    logic          row_done;
    logic          select_first;
    logic          select_next;
    logic          row_start;
    logic          row_latch;
    logic [CW-1:0] col_idx;
    logic          blank;
    logic          frame_start;
    logic          busy;

    int checks = 0;
    int fails  = 0;
    int n_first = 0;
    int n_next  = 0;

    typedef struct {
        int dwell;
        int hold;
        int exp_col;
        bit exp_frame;
        int exp_blank;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    matrix_scan_scheduler #(
        .NUM_COLUMNS (NC),
        .DWELL_W     (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .dwell_cycles (dwell_cycles),
        .col_ready    (col_ready),
        .select_first (select_first),
        .select_next  (select_next),
        .row_start    (row_start),
        .row_done     (row_done),
        .row_latch    (row_latch),
        .col_idx      (col_idx),
        .blank        (blank),
        .frame_start  (frame_start),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " select_first"}, select_first, 0);
        check({tag, " select_next"}, select_next, 0);
        check({tag, " row_start"}, row_start, 0);
        check({tag, " row_latch"}, row_latch, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " blank"}, blank, 1);
        check({tag, " col_idx"}, col_idx, 0);
    endtask

    // One full column: row load, select handshake, latch, dwell.
    task automatic run_column(input int dwell, input int hold, input int exp_col,
                              input bit exp_frame, input int exp_blank, input bit drop_en);
        int t;
        int lows;
        bit first_exp;
        first_exp    = (exp_col == 0);
        dwell_cycles = DW'(dwell);
        col_ready    = 1'b1;

        t = 0;
        while (!row_start && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("row_start seen", row_start, 1);
        check("col_idx at row_start", col_idx, exp_col);
        check("frame_start with row_start", frame_start, exp_frame);
        check("blank during row load", blank, 1);

        repeat (3) @(negedge clk);
        check("no select before row_done", select_first | select_next, 0);
        row_done = 1'b1;
        @(negedge clk);
        row_done = 1'b0;
        check("select_first level", select_first, first_exp);
        check("select_next level", select_next, !first_exp);
        if (select_first) n_first++;
        if (select_next) n_next++;

        for (int i = 0; i < hold; i++) begin
            check("select held", first_exp ? select_first : select_next, 1);
            check("selects exclusive", select_first & select_next, 0);
            @(negedge clk);
        end
        col_ready = 1'b0;
        check("select high as col_ready falls", first_exp ? select_first : select_next, 1);
        @(negedge clk);
        check("select dropped", select_first | select_next, 0);
        @(negedge clk);
        check("no latch while col_ready low", row_latch, 0);
        col_ready = 1'b1;

        t = 0;
        while (!row_latch && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("row_latch seen", row_latch, 1);
        check("blank at latch", blank, 1);

        lows = 0;
        t    = 0;
        @(negedge clk);
        while (!blank && t < 1000) begin
            lows++;
            if (drop_en && lows == 1) enable = 1'b0;
            @(negedge clk);
            t++;
        end
        check("blank low cycles", lows, exp_blank);
        check("col_idx stable through next", col_idx, exp_col);
        check("busy in column", busy, 1);
    endtask

    initial begin
        vecs[0]  = '{10, 5,  0, 1, 10};
        vecs[1]  = '{ 0, 5,  1, 0,  1};
        vecs[2]  = '{ 1, 0,  2, 0,  1};
        vecs[3]  = '{ 2, 1,  3, 0,  2};
        vecs[4]  = '{ 3, 2,  4, 0,  3};
        vecs[5]  = '{ 4, 3,  5, 0,  4};
        vecs[6]  = '{ 5, 4,  6, 0,  5};
        vecs[7]  = '{ 6, 0,  7, 0,  6};
        vecs[8]  = '{ 7, 1,  8, 0,  7};
        vecs[9]  = '{ 8, 2,  9, 0,  8};
        vecs[10] = '{ 9, 3, 10, 0,  9};
        vecs[11] = '{11, 4, 11, 0, 11};
        vecs[12] = '{12, 0, 12, 0, 12};
        vecs[13] = '{13, 1, 13, 0, 13};
        vecs[14] = '{14, 2, 14, 0, 14};
        vecs[15] = '{15, 3, 15, 0, 15};
        vecs[16] = '{ 0, 4,  0, 1,  1};
        vecs[17] = '{10, 5,  1, 0, 10};

        rst_n        = 1'b0;
        enable       = 1'b0;
        col_ready    = 1'b1;
        row_done     = 1'b0;
        dwell_cycles = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle busy while disabled", busy, 0);
        check("idle blank while disabled", blank, 1);
        check("idle no row_start", row_start, 0);

        enable = 1'b1;
        for (int i = 0; i < 18; i++) begin
            run_column(vecs[i].dwell, vecs[i].hold, vecs[i].exp_col,
                       vecs[i].exp_frame, vecs[i].exp_blank, 1'b0);
            if (i == 15) begin
                check("select_first per frame", n_first, 1);
                check("select_next per frame", n_next, 15);
            end
        end
        check("select_first after wrap", n_first, 2);

        // Reset asserted while column 2 is requesting from column_select.
        begin
            int t;
            t = 0;
            while (!row_start && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("col 2 row_start", row_start, 1);
            repeat (3) @(negedge clk);
            row_done = 1'b1;
            @(negedge clk);
            row_done = 1'b0;
            check("col 2 select_next before reset", select_next, 1);
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async reset");
            @(negedge clk);
            rst_n = 1'b1;
        end

        n_first = 0;
        run_column(3, 1, 0, 1, 3, 1'b0);
        check("restart uses select_first", n_first, 1);

        for (int c = 1; c <= 4; c++) begin
            run_column(2, 1, c, 0, 2, c == 4);
        end
        @(negedge clk);
        check("stopped col_idx", col_idx, 5);
        check("stopped busy", busy, 0);
        check("stopped blank", blank, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stays idle", busy | row_start, 0);
        end

        enable = 1'b1;
        run_column(3, 0, 0, 1, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
